// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared codes, FSM encoding and key decode for the keypad scanner
// Key map is row-major: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
package keypad_pkg;

  localparam logic [2:0] OPT_ADD = 3'd0;
  localparam logic [2:0] OPT_SUB = 3'd1;
  localparam logic [2:0] OPT_MUL = 3'd2;
  localparam logic [2:0] OPT_DIV = 3'd3;
  localparam logic [2:0] OPT_CLR = 3'd4;

  localparam logic [1:0] KEY_DIGIT  = 2'd0;
  localparam logic [1:0] KEY_OPT    = 2'd1;
  localparam logic [1:0] KEY_SUBMIT = 2'd2;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_LOAD,
    ST_STROBE,
    ST_RELEASE
  } state_e;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] value;
  } key_t;

  // Rows are active-low; row 0 wins when several are low together.
  function automatic logic [1:0] lowest_row(input logic [3:0] pat);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic key_t decode_key(input logic [1:0] r, input logic [1:0] c);
    key_t k;
    k.cls   = KEY_DIGIT;
    k.value = 4'd0;
    case ({r, c})
      4'h0: k.value = 4'd1;
      4'h1: k.value = 4'd2;
      4'h2: k.value = 4'd3;
      4'h3: k = '{KEY_OPT, {1'b0, OPT_ADD}};
      4'h4: k.value = 4'd4;
      4'h5: k.value = 4'd5;
      4'h6: k.value = 4'd6;
      4'h7: k = '{KEY_OPT, {1'b0, OPT_SUB}};
      4'h8: k.value = 4'd7;
      4'h9: k.value = 4'd8;
      4'hA: k.value = 4'd9;
      4'hB: k = '{KEY_OPT, {1'b0, OPT_MUL}};
      4'hC: k = '{KEY_OPT, {1'b0, OPT_CLR}};
      4'hD: k.value = 4'd0;
      4'hE: k = '{KEY_SUBMIT, 4'd0};
      default: k = '{KEY_OPT, {1'b0, OPT_DIV}};
    endcase
    return k;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle scan tick
// A divide ratio of 0 or 1 collapses the counter to a constant-high tick.
module tick_gen #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = (DIV > 1) ? CW'(DIV - 1) : '0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, row debounce and one-shot key decode
// num/opt are updated in LOAD, one cycle ahead of the STROBE-driven pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ       = 25000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] opt,
  output logic       optPressed,
  output logic       submit
);

  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_TICKS);

  logic           tick;
  state_e         state_q;
  logic [3:0]     row_meta_q, row_sync_q, pat_q, col_q, num_q;
  logic [1:0]     col_idx_q, cls_q;
  logic [DBW-1:0] dbc_q;
  logic [2:0]     opt_q;
  logic           np_q, op_q, sub_q;
  logic [DBW-1:0] dbc_inc;
  key_t           key_w;

  tick_gen #(.DIV(CLK_FREQ / SCAN_HZ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign dbc_inc = dbc_q + DBW'(1);
  assign key_w   = decode_key(lowest_row(pat_q), col_idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SCAN;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      pat_q      <= 4'hF;
      col_q      <= 4'b1110;
      col_idx_q  <= 2'd0;
      dbc_q      <= '0;
      cls_q      <= KEY_DIGIT;
      num_q      <= 4'd0;
      opt_q      <= 3'd0;
      np_q       <= 1'b0;
      op_q       <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      np_q       <= 1'b0;
      op_q       <= 1'b0;
      sub_q      <= 1'b0;
      case (state_q)
        ST_SCAN: if (tick) begin
          if (row_sync_q == 4'hF) begin
            col_q     <= {col_q[2:0], col_q[3]};
            col_idx_q <= col_idx_q + 2'd1;
          end else begin
            pat_q   <= row_sync_q;
            dbc_q   <= '0;
            state_q <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: if (tick) begin
          if (row_sync_q == pat_q) begin
            dbc_q <= dbc_inc;
            if (dbc_inc == DB_MAX) state_q <= ST_LOAD;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_LOAD: begin
          cls_q <= key_w.cls;
          if (key_w.cls == KEY_DIGIT)    num_q <= key_w.value;
          else if (key_w.cls == KEY_OPT) opt_q <= key_w.value[2:0];
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          np_q    <= (cls_q == KEY_DIGIT);
          op_q    <= (cls_q == KEY_OPT);
          sub_q   <= (cls_q == KEY_SUBMIT);
          dbc_q   <= '0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: if (tick) begin
          // Any low row on the held column restarts the release count.
          if (row_sync_q == 4'hF) begin
            dbc_q <= dbc_inc;
            if (dbc_inc == DB_MAX) begin
              state_q   <= ST_SCAN;
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end else begin
            dbc_q <= '0;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign col        = col_q;
  assign num        = num_q;
  assign opt        = opt_q;
  assign numPressed = np_q;
  assign optPressed = op_q;
  assign submit     = sub_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a behavioural keypad matrix
// Keys are indexed r*4+c; a held key pulls its row low while its column is driven low.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row, col, num;
  logic [2:0]  opt;
  logic        numPressed, optPressed, submit;
  logic [15:0] key_down = 16'h0000;

  int passed = 0, total = 0;
  int np_cnt = 0, op_cnt = 0, sub_cnt = 0;
  int excl_viol = 0, b2b_viol = 0, stable_viol = 0;
  logic [3:0] num_prev = 4'd0;
  logic       prev_any = 1'b0;
  int np0, op0, sub0, w;

  keypad_scanner #(
    .CLK_FREQ(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .num       (num),
    .numPressed(numPressed),
    .opt       (opt),
    .optPressed(optPressed),
    .submit    (submit)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (numPressed) np_cnt++;
    if (optPressed) op_cnt++;
    if (submit) sub_cnt++;
    if ((32'(numPressed) + 32'(optPressed) + 32'(submit)) > 1) excl_viol++;
    if ((numPressed || optPressed || submit) && prev_any) b2b_viol++;
    if (numPressed && num !== num_prev) stable_viol++;
    prev_any = numPressed || optPressed || submit;
    num_prev = num;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target, input int bound, output int waited);
    waited = 0;
    while (col !== target && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic snap();
    np0 = np_cnt; op0 = op_cnt; sub0 = sub_cnt;
  endtask

  initial begin
    // 1: reset values and free-running column rotation
    cycles(5);
    reset = 1'b0;
    check("rst_col", col, 4'b1110);
    check("rst_num", num, 0);
    check("rst_opt", opt, 0);
    check("rst_strobes", {numPressed, optPressed, submit}, 0);
    wait_col(4'b1101, 40, w); check("rot_1101", col, 4'b1101);
    wait_col(4'b1011, 40, w); check("rot_1011", col, 4'b1011); check("rot_gap1", w, 10);
    wait_col(4'b0111, 40, w); check("rot_0111", col, 4'b0111); check("rot_gap2", w, 10);
    wait_col(4'b1110, 40, w); check("rot_1110", col, 4'b1110); check("rot_gap3", w, 10);

    // 2: key '6' held, then released
    snap();
    key_down = 16'h0040;
    cycles(100);
    check("k6_pulses", np_cnt - np0, 1);
    check("k6_num", num, 6);
    check("k6_col_held", col, 4'b1011);
    key_down = 16'h0000;
    wait_col(4'b0111, 60, w);
    check("k6_release_rot", col, 4'b0111);
    check("k6_no_repeat", np_cnt - np0, 1);

    // 3: key '5' bouncing, then stable
    snap();
    for (int i = 0; i < 5; i++) begin
      key_down = 16'h0020; cycles(10);
      key_down = 16'h0000; cycles(10);
    end
    check("k5_bounce_quiet", np_cnt - np0, 0);
    key_down = 16'h0020;
    cycles(100);
    check("k5_pulses", np_cnt - np0, 1);
    check("k5_num", num, 5);
    key_down = 16'h0000;
    cycles(60);
    check("k5_no_repeat", np_cnt - np0, 1);

    // 4: 'C', '*', '#'
    snap();
    key_down = 16'h0800; cycles(100);
    check("kC_opt", opt, 2);
    check("kC_pulses", op_cnt - op0, 1);
    check("kC_num_kept", num, 5);
    key_down = 16'h0000; cycles(60);
    key_down = 16'h1000; cycles(100);
    check("kstar_opt", opt, 4);
    check("kstar_pulses", op_cnt - op0, 2);
    key_down = 16'h0000; cycles(60);
    key_down = 16'h4000; cycles(100);
    check("khash_submit", sub_cnt - sub0, 1);
    check("khash_opt_kept", opt, 4);
    check("khash_num_kept", num, 5);
    check("khash_no_other", (np_cnt - np0) + (op_cnt - op0 - 2), 0);
    key_down = 16'h0000; cycles(60);

    // 5: '1' and '4' together, partial release, full release
    snap();
    key_down = 16'h0011; cycles(100);
    check("k14_pulses", np_cnt - np0, 1);
    check("k14_num", num, 1);
    key_down = 16'h0010; cycles(100);
    check("k14_partial_quiet", np_cnt - np0, 1);
    check("k14_col_held", col, 4'b1110);
    key_down = 16'h0000; cycles(60);
    check("k14_full_release", np_cnt - np0 + op_cnt - op0 + sub_cnt - sub0, 1);

    // 6: reset during debounce of '9'
    wait_col(4'b0111, 60, w);
    check("k9_sync_col", col, 4'b0111);
    snap();
    key_down = 16'h0400;
    wait_col(4'b1011, 60, w);
    check("k9_reach_col", col, 4'b1011);
    cycles(15);
    reset = 1'b1;
    cycles(3);
    check("k9_rst_no_strobe", np_cnt - np0 + op_cnt - op0 + sub_cnt - sub0, 0);
    check("k9_rst_col", col, 4'b1110);
    check("k9_rst_num", num, 0);
    check("k9_rst_opt", opt, 0);
    reset = 1'b0;
    cycles(100);
    check("k9_pulses", np_cnt - np0, 1);
    check("k9_num", num, 9);
    key_down = 16'h0000; cycles(60);

    check("strobe_exclusive", excl_viol, 0);
    check("strobe_back_to_back", b2b_viol, 0);
    check("num_setup_before_strobe", stable_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
